// File: rtl/bram_dp_param.sv
// Simple-dual-port block RAM: port A read/write with byte-lane enables, port B read-only.
// Selectable collision behaviour, optional output register stage and a valid strobe per port.
module bram_dp_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 11,
  parameter int BYTE_WIDTH = 8,
  parameter int READ_MODE  = 0,
  parameter int OUT_REG    = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = {(DATA_WIDTH/8){8'h5A}},
  localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  A_EN,
  input  logic [NUM_BYTES-1:0]  A_WE,
  input  logic [ADDR_WIDTH-1:0] A_ADDR,
  input  logic [DATA_WIDTH-1:0] A_DIN,
  output logic [DATA_WIDTH-1:0] A_DOUT,
  output logic                  A_VALID,
  input  logic                  B_EN,
  input  logic [ADDR_WIDTH-1:0] B_ADDR,
  output logic [DATA_WIDTH-1:0] B_DOUT,
  output logic                  B_VALID
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  generate
    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
      $fatal(1, "bram_dp_param: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (READ_MODE != 0 && READ_MODE != 1) begin : g_bad_mode
      $fatal(1, "bram_dp_param: READ_MODE must be 0 or 1");
    end
  endgenerate

  // Array is deliberately outside reset so it maps onto block RAM with bitstream init.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: INIT_VALUE};

  logic                  a_acc;
  logic                  b_acc;
  logic                  a_wr;
  logic [DATA_WIDTH-1:0] a_old;
  logic [DATA_WIDTH-1:0] b_old;
  logic [DATA_WIDTH-1:0] a_merged;
  logic [DATA_WIDTH-1:0] a_rdata_d;
  logic [DATA_WIDTH-1:0] b_rdata_d;

  always_comb begin
    a_acc    = !RST && A_EN;
    b_acc    = !RST && B_EN;
    a_wr     = a_acc && (|A_WE);
    a_old    = mem_q[A_ADDR];
    b_old    = mem_q[B_ADDR];
    a_merged = a_old;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (A_WE[i]) begin
        a_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = A_DIN[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
    a_rdata_d = (READ_MODE == 1) ? a_merged : a_old;
    b_rdata_d = (READ_MODE == 1 && a_wr && (A_ADDR == B_ADDR)) ? a_merged : b_old;
  end

  always_ff @(posedge CLK) begin
    if (a_acc) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (A_WE[i]) begin
          mem_q[A_ADDR][i*BYTE_WIDTH +: BYTE_WIDTH] <= A_DIN[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  logic                  a_vld1_q;
  logic                  b_vld1_q;
  logic [DATA_WIDTH-1:0] a_dat1_q;
  logic [DATA_WIDTH-1:0] b_dat1_q;

  // Data registers load only on an accepted access so outputs hold between strobes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      a_vld1_q <= 1'b0;
      b_vld1_q <= 1'b0;
      a_dat1_q <= '0;
      b_dat1_q <= '0;
    end else begin
      a_vld1_q <= a_acc;
      b_vld1_q <= b_acc;
      if (a_acc) a_dat1_q <= a_rdata_d;
      if (b_acc) b_dat1_q <= b_rdata_d;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                  a_vld2_q;
      logic                  b_vld2_q;
      logic [DATA_WIDTH-1:0] a_dat2_q;
      logic [DATA_WIDTH-1:0] b_dat2_q;

      always_ff @(posedge CLK) begin
        if (RST) begin
          a_vld2_q <= 1'b0;
          b_vld2_q <= 1'b0;
          a_dat2_q <= '0;
          b_dat2_q <= '0;
        end else begin
          a_vld2_q <= a_vld1_q;
          b_vld2_q <= b_vld1_q;
          if (a_vld1_q) a_dat2_q <= a_dat1_q;
          if (b_vld1_q) b_dat2_q <= b_dat1_q;
        end
      end

      assign A_DOUT  = a_dat2_q;
      assign A_VALID = a_vld2_q;
      assign B_DOUT  = b_dat2_q;
      assign B_VALID = b_vld2_q;
    end else begin : g_no_out_reg
      assign A_DOUT  = a_dat1_q;
      assign A_VALID = a_vld1_q;
      assign B_DOUT  = b_dat1_q;
      assign B_VALID = b_vld1_q;
    end
  endgenerate

endmodule

// File: tb/tb_bram_dp_param.sv
// Bench for bram_dp_param: two 32-bit instances share one stimulus stream.
// Instance d uses OUT_REG=d and READ_MODE=d; a latency/event-queue model predicts both.
module tb_bram_dp_param;

  logic             clk;
  logic             rst;
  logic             a_en;
  logic [3:0]       a_we;
  logic [10:0]      a_addr;
  logic [31:0]      a_din;
  logic             b_en;
  logic [10:0]      b_addr;
  logic [1:0][31:0] a_dout;
  logic [1:0][31:0] b_dout;
  logic [1:0]       a_vld;
  logic [1:0]       b_vld;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;

  typedef struct {
    int          due;
    int          d;
    bit          is_b;
    logic [31:0] data;
  } ev_t;

  ev_t              evq[$];
  logic [31:0]      mdl [2048];
  bit   [1:0]       e_av;
  bit   [1:0]       e_bv;
  logic [1:0][31:0] e_ad;
  logic [1:0][31:0] e_bd;

  bram_dp_param #(
    .DATA_WIDTH(32), .ADDR_WIDTH(11), .BYTE_WIDTH(8),
    .READ_MODE(0), .OUT_REG(0), .INIT_VALUE(32'h5A5A_5A5A)
  ) u_dut0 (
    .CLK(clk), .RST(rst),
    .A_EN(a_en), .A_WE(a_we), .A_ADDR(a_addr), .A_DIN(a_din),
    .A_DOUT(a_dout[0]), .A_VALID(a_vld[0]),
    .B_EN(b_en), .B_ADDR(b_addr),
    .B_DOUT(b_dout[0]), .B_VALID(b_vld[0])
  );

  bram_dp_param #(
    .DATA_WIDTH(32), .ADDR_WIDTH(11), .BYTE_WIDTH(8),
    .READ_MODE(1), .OUT_REG(1), .INIT_VALUE(32'h5A5A_5A5A)
  ) u_dut1 (
    .CLK(clk), .RST(rst),
    .A_EN(a_en), .A_WE(a_we), .A_ADDR(a_addr), .A_DIN(a_din),
    .A_DOUT(a_dout[1]), .A_VALID(a_vld[1]),
    .B_EN(b_en), .B_ADDR(b_addr),
    .B_DOUT(b_dout[1]), .B_VALID(b_vld[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge: results appear OUT_REG edges after the accepting edge; reset drops all pending.
  task automatic step();
    logic [31:0] old_a, old_b, merged;
    logic [10:0] la, lb;
    bit          acc_a, acc_b, wr;
    ev_t         ev;
    ev_t         keep[$];
    la     = a_addr;
    lb     = b_addr;
    old_a  = mdl[la];
    old_b  = mdl[lb];
    merged = old_a;
    for (int i = 0; i < 4; i++) if (a_we[i]) merged[i*8 +: 8] = a_din[i*8 +: 8];
    acc_a = !rst && a_en;
    acc_b = !rst && b_en;
    wr    = acc_a && (a_we != 4'b0);
    @(posedge clk);
    edge_n++;
    if (rst) begin
      evq.delete();
      e_ad = '0;
      e_bd = '0;
    end else begin
      if (wr) mdl[la] = merged;
      for (int d = 0; d < 2; d++) begin
        if (acc_a) begin
          ev.due = edge_n + d; ev.d = d; ev.is_b = 1'b0;
          ev.data = (d == 1) ? merged : old_a;
          evq.push_back(ev);
        end
        if (acc_b) begin
          ev.due = edge_n + d; ev.d = d; ev.is_b = 1'b1;
          ev.data = (d == 1 && wr && la == lb) ? merged : old_b;
          evq.push_back(ev);
        end
      end
    end
    e_av = '0;
    e_bv = '0;
    foreach (evq[k]) begin
      if (evq[k].due == edge_n) begin
        if (evq[k].is_b) begin e_bv[evq[k].d] = 1'b1; e_bd[evq[k].d] = evq[k].data; end
        else             begin e_av[evq[k].d] = 1'b1; e_ad[evq[k].d] = evq[k].data; end
      end else begin
        keep.push_back(evq[k]);
      end
    end
    evq = keep;
    #1;
  endtask

  task automatic idle_inputs();
    a_en = 0; a_we = '0; a_addr = '0; a_din = '0; b_en = 0; b_addr = '0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    for (int c = 0; c < 2; c++) begin
      step();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (a_vld[d] !== 1'b0 || b_vld[d] !== 1'b0 || a_dout[d] !== 32'h0 || b_dout[d] !== 32'h0) begin
          errors++;
          $display("FAIL reset dut%0d: a_vld=%b b_vld=%b a_dout=%h b_dout=%h, want all zero",
                   d, a_vld[d], b_vld[d], a_dout[d], b_dout[d]);
        end
      end
    end
    rst = 0;
  endtask

  task automatic test_init();
    logic [10:0] addrs [2];
    addrs[0] = 11'h000;
    addrs[1] = 11'h7FF;
    for (int r = 0; r < 2; r++) begin
      idle_inputs();
      b_en = 1; b_addr = addrs[r];
      for (int c = 0; c < 3; c++) begin
        step();
        idle_inputs();
        for (int d = 0; d < 2; d++) begin
          checks++;
          if (b_vld[d] !== (c == d) || (c == d && b_dout[d] !== 32'h5A5A_5A5A)) begin
            errors++;
            $display("FAIL init_read dut%0d addr=%h cyc=%0d: valid=%b data=%h, want valid=%b data=5a5a5a5a",
                     d, addrs[r], c, b_vld[d], b_dout[d], (c == d));
          end
        end
      end
    end
  endtask

  task automatic test_byte_enable();
    idle_inputs();
    a_en = 1; a_we = 4'b1111; a_addr = 11'd5; a_din = 32'hAABB_CCDD;
    step();
    a_we = 4'b0101; a_din = 32'h1122_3344;
    step();
    idle_inputs();
    b_en = 1; b_addr = 11'd5;
    for (int c = 0; c < 3; c++) begin
      step();
      idle_inputs();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (b_vld[d] !== e_bv[d] || b_dout[d] !== e_bd[d] ||
            (b_vld[d] && b_dout[d] !== 32'hAA22_CC44)) begin
          errors++;
          $display("FAIL byte_enable dut%0d cyc=%0d: valid=%b data=%h, want valid=%b data=%h (aa22cc44)",
                   d, c, b_vld[d], b_dout[d], e_bv[d], e_bd[d]);
        end
      end
    end
  endtask

  task automatic test_collision();
    logic [31:0] want_first [2];
    int          seen [2];
    want_first[0] = 32'h5A5A_5A5A;
    want_first[1] = 32'h5A5A_5A3C;
    seen[0] = 0;
    seen[1] = 0;
    idle_inputs();
    a_en = 1; a_we = 4'b0001; a_addr = 11'h010; a_din = 32'h0000_003C;
    b_en = 1; b_addr = 11'h010;
    step();
    idle_inputs();
    b_en = 1; b_addr = 11'h010;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin
        step();
        idle_inputs();
      end
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (b_vld[d] !== e_bv[d] || b_dout[d] !== e_bd[d] || a_vld[d] !== e_av[d] || a_dout[d] !== e_ad[d]) begin
          errors++;
          $display("FAIL collision_model dut%0d cyc=%0d: a=%b/%h b=%b/%h, want a=%b/%h b=%b/%h",
                   d, c, a_vld[d], a_dout[d], b_vld[d], b_dout[d], e_av[d], e_ad[d], e_bv[d], e_bd[d]);
        end
        if (b_vld[d] === 1'b1) begin
          checks++;
          if (b_dout[d] !== ((seen[d] == 0) ? want_first[d] : 32'h5A5A_5A3C)) begin
            errors++;
            $display("FAIL collision dut%0d read#%0d: got %h, want %h", d, seen[d], b_dout[d],
                     (seen[d] == 0) ? want_first[d] : 32'h5A5A_5A3C);
          end
          seen[d]++;
        end
      end
    end
  endtask

  task automatic test_streaming();
    int cnt [2];
    int first [2];
    int last [2];
    for (int i = 0; i < 8; i++) begin
      idle_inputs();
      a_en = 1; a_we = 4'hF; a_addr = 11'(i); a_din = 32'(i);
      step();
    end
    for (int d = 0; d < 2; d++) begin cnt[d] = 0; first[d] = -1; last[d] = -1; end
    for (int c = 0; c < 11; c++) begin
      idle_inputs();
      if (c < 8) begin b_en = 1; b_addr = 11'(c); end
      step();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (b_vld[d] !== e_bv[d] || b_dout[d] !== e_bd[d] || (b_vld[d] && b_dout[d] !== 32'(cnt[d]))) begin
          errors++;
          $display("FAIL stream dut%0d cyc=%0d: valid=%b data=%h, want valid=%b data=%h", d, c,
                   b_vld[d], b_dout[d], e_bv[d], e_bd[d]);
        end
        if (b_vld[d] === 1'b1) begin
          if (first[d] < 0) first[d] = c;
          last[d] = c;
          cnt[d]++;
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (cnt[d] != 8 || first[d] != d || last[d] != d + 7) begin
        errors++;
        $display("FAIL stream_window dut%0d: count=%0d first=%0d last=%0d, want 8 %0d %0d",
                 d, cnt[d], first[d], last[d], d, d + 7);
      end
    end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    b_en = 1; b_addr = 11'h7FF;
    step();
    idle_inputs();
    rst = 1; a_en = 1; a_we = 4'hF; a_addr = 11'h020; a_din = 32'hCAFE_F00D;
    step();
    checks++;
    if (b_vld[1] !== 1'b0 || b_dout[1] !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_discard dut1: valid=%b data=%h, want 0/00000000", b_vld[1], b_dout[1]);
    end
    rst = 0;
    idle_inputs();
    step();
    checks++;
    if (b_vld[1] !== 1'b0 || b_dout[1] !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_after dut1: valid=%b data=%h, want 0/00000000", b_vld[1], b_dout[1]);
    end
    b_en = 1; b_addr = 11'h020;
    for (int c = 0; c < 3; c++) begin
      step();
      idle_inputs();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (b_vld[d] !== e_bv[d] || b_dout[d] !== e_bd[d] || (b_vld[d] && b_dout[d] !== 32'h5A5A_5A5A)) begin
          errors++;
          $display("FAIL reset_no_write dut%0d cyc=%0d: valid=%b data=%h, want valid=%b data=5a5a5a5a",
                   d, c, b_vld[d], b_dout[d], e_bv[d]);
        end
      end
    end
  endtask

  task automatic test_enable_gating();
    idle_inputs();
    a_en = 1; a_we = 4'b0000; a_addr = 11'h040;
    step();
    idle_inputs();
    step();
    a_en = 0; a_we = 4'hF; a_addr = 11'h040; a_din = 32'hDEAD_BEEF;
    for (int c = 0; c < 3; c++) begin
      step();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (a_vld[d] !== 1'b0 || a_dout[d] !== 32'h5A5A_5A5A) begin
          errors++;
          $display("FAIL enable_gating dut%0d cyc=%0d: a_valid=%b a_dout=%h, want 0/5a5a5a5a",
                   d, c, a_vld[d], a_dout[d]);
        end
      end
    end
    idle_inputs();
    b_en = 1; b_addr = 11'h040;
    for (int c = 0; c < 3; c++) begin
      step();
      idle_inputs();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (b_vld[d] !== e_bv[d] || b_dout[d] !== e_bd[d] || (b_vld[d] && b_dout[d] !== 32'h5A5A_5A5A)) begin
          errors++;
          $display("FAIL gated_no_write dut%0d cyc=%0d: valid=%b data=%h, want valid=%b data=5a5a5a5a",
                   d, c, b_vld[d], b_dout[d], e_bv[d]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst    = ($urandom_range(0, 39) == 0);
      a_en   = $urandom_range(0, 1);
      a_we   = 4'($urandom);
      a_addr = 11'($urandom_range(0, 15));
      a_din  = $urandom;
      b_en   = $urandom_range(0, 1);
      b_addr = ($urandom_range(0, 2) == 0) ? a_addr : 11'($urandom_range(0, 15));
      step();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (a_vld[d] !== e_av[d] || a_dout[d] !== e_ad[d] || b_vld[d] !== e_bv[d] || b_dout[d] !== e_bd[d]) begin
          errors++;
          $display("FAIL random dut%0d cyc=%0d: a=%b/%h b=%b/%h, want a=%b/%h b=%b/%h",
                   d, c, a_vld[d], a_dout[d], b_vld[d], b_dout[d], e_av[d], e_ad[d], e_bv[d], e_bd[d]);
        end
      end
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mdl[i] = 32'h5A5A_5A5A;
    e_av = '0; e_bv = '0; e_ad = '0; e_bd = '0;
    rst = 1;
    idle_inputs();
    #2;
    test_reset();
    test_init();
    test_byte_enable();
    test_collision();
    test_streaming();
    test_reset_mid();
    test_enable_gating();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
